aes_frame_writer: RTL and testbench
===================================

Name: aes_frame_writer

Overview:
- Upstream neighbour of the VGA display stage.
- Takes 128-bit AES result blocks from the SIMD pipeline over a valid/ready handshake and serializes each block into 16 pixel bytes.
- Writes the bytes into the pixel frame memory that the display reads from.
- Writes to the plaintext region (base 0) or the ciphertext region (base CIPHER_BASE), so the display's switch can select either image.

Parameters:
- IMG_PIXELS, 10000, bytes per image; the frame ends after this many writes.
- CIPHER_BASE, 10001, base address of the ciphertext region.
- ADDR_W, 16, width of the frame-memory address.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame (honoured in IDLE only).
- region  in  1  sampled with start; 0 = plaintext base 0, 1 = ciphertext base CIPHER_BASE.
- blk_valid  in  1  upstream block valid.
- blk_data  in  128  AES block; byte 0 = [127:120], byte 15 = [7:0].
- blk_ready  out  1  block accepted on a cycle with blk_valid && blk_ready.
- wr_en  out  1  frame-memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8  pixel byte.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last pixel is written.
- checksum  out  16  frame checksum (see Optional Feature).

Behaviour:
- Reset: state=IDLE; blk_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, checksum=0.
- Reset mid-frame: aborts immediately; no further writes; done is not pulsed.
- States:
  - IDLE: outputs low. On start, latch base = region ? CIPHER_BASE : 0, set pix_cnt=0, busy=1, go to WAIT_BLK.
  - WAIT_BLK: blk_ready=1. On handshake, load the 128-bit shift register, byte_idx=0, go to EMIT.
  - EMIT: each cycle, wr_en=1, wr_addr=base+pix_cnt, wr_data=current byte (MSB first); then pix_cnt++ and byte_idx++.
    - blk_ready=1 only on the byte_idx==15 cycle, and only if pix_cnt+1 < IMG_PIXELS. A handshake there reloads the shift register and stays in EMIT, so back-to-back blocks write with zero bubbles (16 cycles/block).
    - After byte 15 with no handshake and pixels remaining: go to WAIT_BLK.
    - When the written pixel is number IMG_PIXELS-1: go to DONE. Unwritten bytes of the current block are discarded.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Latency: block accepted in cycle N produces its first write (byte 0) in cycle N+1.
- Address arithmetic: base+pix_cnt in ADDR_W bits, no wrap check. The integrator guarantees CIPHER_BASE+IMG_PIXELS-1 < 2^ADDR_W.
- start while busy: ignored. region is only sampled with start.
- blk_valid while blk_ready=0: no effect; upstream holds blk_data stable until handshake.
- wr_addr and wr_data hold their last values when wr_en=0.

Optional Feature:
- FRAME_CHECKSUM_EN defined:
  - checksum clears to 0 on start acceptance.
  - Each write adds the zero-extended wr_data, modulo 2^16.
  - The final value is valid on the done cycle and holds until the next start.
- Not defined: checksum is constant 0 and no accumulator logic exists.

Test Plan:
- Reset, then start with region=0 and one block 0x000102…0F -> writes addr 0..15, data 0x00..0x0F, one per cycle starting the cycle after handshake; blk_ready then high in WAIT_BLK.
- region=1, IMG_PIXELS=32, two blocks presented back-to-back -> 32 consecutive wr_en cycles at addr 10001..10032 with no gap; done pulses once in the cycle after the last write; busy falls with done.
- IMG_PIXELS=20, two blocks -> 20 writes (addr 0..19); bytes 4..15 of block 2 are dropped; blk_ready is not asserted after the second handshake.
- Upstream stalls 5 cycles between blocks -> wr_en low for those cycles; blk_ready high throughout the stall; addresses continue contiguously.
- rst asserted at the 7th write -> next cycle all outputs return to reset values with no done pulse; a subsequent start restarts at base address.
- FRAME_CHECKSUM_EN, IMG_PIXELS=16, all bytes 0xFF -> checksum=0x0FF0 on the done cycle. Without the macro, checksum=0 throughout.

Source files
------------

// File: rtl/aes_frame_writer_if.sv
// Purpose: block stream from the SIMD AES pipeline into the frame writer.
// Latency: none, this only bundles wires.
// Backpressure: blk_ready from the writer; upstream holds blk_data until blk_valid && blk_ready.
//
// Signals:
//   blk_valid  upstream has a 128-bit block on blk_data
//   blk_data   AES block, byte 0 in [127:120], byte 15 in [7:0]
//   blk_ready  writer can take a block this cycle
interface aes_frame_writer_if;
   logic         blk_valid;
   logic [127:0] blk_data;
   logic         blk_ready;

   modport master (output blk_valid, output blk_data, input  blk_ready);
   modport slave  (input  blk_valid, input  blk_data, output blk_ready);
endinterface

// File: rtl/aes_frame_writer.sv
// Purpose: serialize 128-bit AES blocks into 16 pixel bytes and write them to frame memory.
// Latency: block accepted in cycle N gives its first write (byte 0) in cycle N+1; 16 cycles per block.
// Backpressure: blk_ready only in WAIT_BLK or on the last byte of a block; no bubbles if upstream keeps up.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, region     one-cycle frame start (IDLE only); region 0 = plaintext base 0, 1 = CIPHER_BASE
//   blk               block stream (slave side of aes_frame_writer_if)
//   wr_en/addr/data   frame-memory write port; addr/data hold when wr_en is low
//   busy, done        busy from start acceptance until done; done is a one-cycle pulse
//   checksum          16-bit sum of written bytes when FRAME_CHECKSUM_EN is defined, else constant 0
//
// Build option: define FRAME_CHECKSUM_EN to include the frame checksum accumulator.
module aes_frame_writer #(
   parameter int IMG_PIXELS  = 10000,
   parameter int CIPHER_BASE = 10001,
   parameter int ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              region,
   aes_frame_writer_if.slave blk,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic [15:0]       checksum
);

   typedef enum logic [1:0] {IDLE, WAIT_BLK, EMIT, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);
   localparam logic [ADDR_W-1:0] CBASE    = ADDR_W'(CIPHER_BASE);

   state_t            state;
   logic [ADDR_W-1:0] base;
   // In EMIT: index of the pixel currently on the write port.
   // In WAIT_BLK: index of the next pixel to be written.
   logic [ADDR_W-1:0] pix_cnt;
   logic [3:0]        byte_idx;
   // Bytes 1..15 of the current block still to be emitted, next one in the top byte.
   logic [119:0]      shreg;
   logic [ADDR_W-1:0] pix_nxt;
   logic              hs;

   assign pix_nxt = pix_cnt + ADDR_W'(1);
   assign hs      = blk.blk_valid && blk.blk_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         base          <= '0;
         pix_cnt       <= '0;
         byte_idx      <= '0;
         shreg         <= '0;
         blk.blk_ready <= 1'b0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base          <= region ? CBASE : '0;
                  pix_cnt       <= '0;
                  busy          <= 1'b1;
                  blk.blk_ready <= 1'b1;
                  state         <= WAIT_BLK;
               end
            end

            WAIT_BLK: begin
               if (hs) begin
                  blk.blk_ready <= 1'b0;
                  wr_en         <= 1'b1;
                  wr_addr       <= base + pix_cnt;
                  wr_data       <= blk.blk_data[127:120];
                  shreg         <= blk.blk_data[119:0];
                  byte_idx      <= '0;
                  state         <= EMIT;
               end
            end

            EMIT: begin
               if (pix_cnt == LAST_PIX) begin
                  // Frame complete; any remaining bytes of this block are dropped.
                  wr_en         <= 1'b0;
                  blk.blk_ready <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  state         <= DONE;
               end else if (byte_idx == 4'd15) begin
                  pix_cnt       <= pix_nxt;
                  blk.blk_ready <= 1'b0;
                  if (hs) begin
                     // Back-to-back block: continue without a bubble.
                     wr_en    <= 1'b1;
                     wr_addr  <= base + pix_nxt;
                     wr_data  <= blk.blk_data[127:120];
                     shreg    <= blk.blk_data[119:0];
                     byte_idx <= '0;
                  end else begin
                     wr_en         <= 1'b0;
                     blk.blk_ready <= 1'b1;
                     state         <= WAIT_BLK;
                  end
               end else begin
                  pix_cnt  <= pix_nxt;
                  byte_idx <= byte_idx + 4'd1;
                  wr_addr  <= base + pix_nxt;
                  wr_data  <= shreg[119:112];
                  shreg    <= {shreg[111:0], 8'h00};
                  // Open the handshake on the coming byte-15 cycle only if the
                  // frame still needs pixels beyond that byte.
                  blk.blk_ready <= (byte_idx == 4'd14) && (pix_nxt < LAST_PIX);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FRAME_CHECKSUM_EN
   // Accumulates from the registered write port, so the last byte lands on the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= '0;
      end else if (state == IDLE && start) begin
         checksum <= '0;
      end else if (wr_en) begin
         checksum <= checksum + {8'h00, wr_data};
      end
   end
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_frame_writer.sv
// Purpose: randomized self-checking bench for aes_frame_writer against a queue-based frame model.
// Latency: checks first write one cycle after each handshake and zero bubbles for back-to-back blocks.
// Backpressure: upstream model stalls a random number of ready cycles or presents early valid.
module tb_aes_frame_writer;

   localparam int IMG   = 40;
   localparam int CBASE = 10001;
   localparam int AW    = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic          region;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   logic          done;
   logic [15:0]   checksum;

   aes_frame_writer_if u_if ();

   aes_frame_writer #(
      .IMG_PIXELS  (IMG),
      .CIPHER_BASE (CBASE),
      .ADDR_W      (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .region   (region),
      .blk      (u_if),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .checksum (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Frame model: the frame is the first IMG bytes of the accepted block
   // stream, written to base+i, one per cycle while blocks keep up.
   logic [7:0]  exp_q[$];
   int          base_m;
   int          written;
   int          hs_cnt;
   int          cyc = 0;
   int          first_wr_cyc;
   int          last_wr_cyc;
   int          stall_sum;
   int          cur_stall;
   logic [15:0] cs_m;
   bit          chk_done_now;
   bit          frame_end;
   bit          last_hs;

   task automatic tick();
      logic         hs;
      logic         rst_pre;
      logic [127:0] d;
      logic [15:0]  ea;
      logic [7:0]   eb;
      hs      = u_if.blk_valid && u_if.blk_ready && !rst;
      rst_pre = rst;
      d       = u_if.blk_data;
      @(posedge clk);
      #1;
      cyc++;
      last_hs = hs;
      if (rst_pre) return;
      if (chk_done_now) begin
         chk("done_pulse", done, 1'b1);
         chk("busy_fall", busy, 1'b0);
         chk("wr_en_at_done", wr_en, 1'b0);
`ifdef FRAME_CHECKSUM_EN
         chk("checksum", checksum, cs_m);
`else
         chk("checksum", checksum, 16'h0000);
`endif
         chk_done_now = 0;
         frame_end    = 1;
      end else begin
         chk("done_lo", done, 1'b0);
      end
      if (hs) begin
         hs_cnt++;
         if (hs_cnt >= 2) stall_sum += cur_stall;
         for (int i = 0; i < 16; i++) exp_q.push_back(d[127-8*i -: 8]);
         chk("latency_wr_en", wr_en, 1'b1);
      end
      if (wr_en) begin
         if (exp_q.size() == 0 || written >= IMG) begin
            chk("wr_extra", 1'b1, 1'b0);
         end else begin
            eb = exp_q.pop_front();
            ea = 16'(base_m + written);
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, eb);
            cs_m = cs_m + {8'h00, wr_data};
            written++;
            if (written == 1) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            if (written == IMG) chk_done_now = 1;
         end
      end
   endtask

   function automatic logic [127:0] next_block(input int mode, input int blk_no);
      logic [127:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) begin
         case (mode)
            1:       b[127-8*i -: 8] = 8'(blk_no * 16 + i);
            2:       b[127-8*i -: 8] = 8'hFF;
            default: b[127-8*i -: 8] = 8'($urandom);
         endcase
      end
      return b;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_wr_en"},    wr_en, 1'b0);
      chk({tag, "_wr_addr"},  wr_addr, '0);
      chk({tag, "_wr_data"},  wr_data, 8'h00);
      chk({tag, "_busy"},     busy, 1'b0);
      chk({tag, "_done"},     done, 1'b0);
      chk({tag, "_blk_rdy"},  u_if.blk_ready, 1'b0);
      chk({tag, "_checksum"}, checksum, 16'h0000);
   endtask

   // One frame: mode selects data pattern, stalls enables random upstream
   // stalls, rst_at > 0 asserts reset on that write and aborts the frame.
   task automatic run_frame(input bit reg_b, input int mode, input bit stalls, input int rst_at);
      int  blk_no;
      int  stall_left;
      int  iter;
      bit  aborted;
      exp_q.delete();
      base_m       = reg_b ? CBASE : 0;
      written      = 0;
      hs_cnt       = 0;
      cs_m         = '0;
      stall_sum    = 0;
      chk_done_now = 0;
      frame_end    = 0;
      aborted      = 0;
      blk_no       = 0;
      cur_stall    = stalls ? int'($urandom_range(0, 5)) : 0;
      stall_left   = cur_stall;
      u_if.blk_valid = 1'b0;

      start  = 1'b1;
      region = reg_b;
      tick();
      start  = 1'b0;
      region = 1'($urandom);
      chk("busy_after_start", busy, 1'b1);
      chk("rdy_after_start", u_if.blk_ready, 1'b1);

      iter = 0;
      while (!frame_end && iter < 800) begin
         if (!u_if.blk_valid && u_if.blk_ready) begin
            if (stall_left == 0) begin
               u_if.blk_valid = 1'b1;
               u_if.blk_data  = next_block(mode, blk_no);
            end else begin
               stall_left--;
            end
         end
         if (iter == 3) begin
            start  = 1'b1;
            region = ~reg_b;
         end
         tick();
         start = 1'b0;
         iter++;
         if (last_hs) begin
            blk_no++;
            u_if.blk_valid = 1'b0;
            cur_stall  = stalls ? int'($urandom_range(0, 5)) : 0;
            stall_left = cur_stall;
            if (cur_stall == 0 && $urandom_range(0, 1) == 1) begin
               u_if.blk_valid = 1'b1;
               u_if.blk_data  = next_block(mode, blk_no);
            end
         end
         if (rst_at > 0 && written == rst_at && !frame_end) begin
            rst            = 1'b1;
            u_if.blk_valid = 1'b0;
            tick();
            rst = 1'b0;
            check_idle_outputs("mid_rst");
            chk_done_now = 0;
            aborted      = 1;
            frame_end    = 1;
         end
      end

      u_if.blk_valid = 1'b0;
      if (!frame_end) begin
         chk("frame_timeout", 1'b0, 1'b1);
         rst = 1'b1;
         tick();
         rst = 1'b0;
      end else if (!aborted) begin
         chk("writes_total", 32'(written), 32'(IMG));
         chk("blocks_taken", 32'(hs_cnt), 32'((IMG + 15) / 16));
         chk("write_span", 32'(last_wr_cyc - first_wr_cyc), 32'(IMG - 1 + stall_sum));
         chk("rdy_after_done", u_if.blk_ready, 1'b0);
      end
      tick();
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_wr_en", wr_en, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      region         = 1'b0;
      u_if.blk_valid = 1'b0;
      u_if.blk_data  = '0;
      chk_done_now   = 0;
      frame_end      = 0;
      tick();
      tick();
      rst = 1'b0;
      check_idle_outputs("reset");
      tick();
      chk("reset_hold_rdy", u_if.blk_ready, 1'b0);

      run_frame(1'b0, 1, 1'b0, 0);   // incrementing bytes, plaintext region
      run_frame(1'b1, 0, 1'b0, 0);   // back-to-back, ciphertext region
      run_frame(1'b0, 0, 1'b1, 0);   // stalled upstream
      run_frame(1'b1, 0, 1'b1, 7);   // reset on the 7th write
      run_frame(1'b1, 0, 1'b0, 0);   // restart after reset at base
      run_frame(1'b0, 2, 1'b0, 0);   // all 0xFF bytes
      for (int f = 0; f < 8; f++) begin
         run_frame(1'($urandom), 0, 1'($urandom), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
